// File: rtl/yuv2rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : yuv2rgb_pkg
// Brief   : Coefficient sets, standard enum and offset helpers for YUV->RGB.
// Revision: 1.0
// ============================================================================
package yuv2rgb_pkg;

  typedef enum logic {
    STD_601 = 1'b0,
    STD_709 = 1'b1
  } std_e;

  typedef struct packed {
    logic [9:0] ky;
    logic [9:0] krv;
    logic [9:0] kgu;
    logic [9:0] kgv;
    logic [9:0] kbu;
  } coef_t;

  // Indexed by {std, full_range}; all values scaled by 256.
  localparam coef_t COEF_TABLE [4] = '{
    '{ky: 10'd298, krv: 10'd409, kgu: 10'd100, kgv: 10'd208, kbu: 10'd516},
    '{ky: 10'd256, krv: 10'd359, kgu: 10'd88,  kgv: 10'd183, kbu: 10'd454},
    '{ky: 10'd298, krv: 10'd459, kgu: 10'd55,  kgv: 10'd136, kbu: 10'd541},
    '{ky: 10'd256, krv: 10'd403, kgu: 10'd48,  kgv: 10'd120, kbu: 10'd475}
  };

  function automatic int y_offset(input int data_w);
    return 16 << (data_w - 8);
  endfunction

  function automatic int c_offset(input int data_w);
    return 128 << (data_w - 8);
  endfunction

  function automatic logic [1:0] coef_sel(input std_e std, input logic full_range);
    return {std, full_range};
  endfunction

endpackage
`default_nettype wire

// File: rtl/yuv2rgb_core.sv
`default_nettype none
// ============================================================================
// Module  : yuv2rgb_core
// Brief   : Three-stage offset/multiply/round-clamp datapath with valid/last
//           sideband; per-pixel clamp count when YUV2RGB_CLAMP_CNT_EN is set.
// Revision: 1.0
// ============================================================================
module yuv2rgb_core
  import yuv2rgb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic                cfg_std,
  input  logic                cfg_full_range,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   in_y,
  input  logic [DATA_W-1:0]   in_u,
  input  logic [DATA_W-1:0]   in_v,
  output logic                s3_valid,
  output logic                s3_last,
  output logic [3*DATA_W-1:0] s3_pix
`ifdef YUV2RGB_CLAMP_CNT_EN
  ,
  output logic [1:0]          s3_clamps
`endif
);

  localparam int IW = DATA_W + FRAC + 4;
  typedef logic signed [IW-1:0] sval_t;

  localparam sval_t C_YOFF = sval_t'(y_offset(DATA_W));
  localparam sval_t C_COFF = sval_t'(c_offset(DATA_W));
  localparam sval_t C_RND  = sval_t'(1 << (FRAC - 1));
  localparam sval_t C_MAX  = sval_t'((1 << DATA_W) - 1);

  function automatic logic is_over(input sval_t x);
    return x[IW-1] || (x > C_MAX);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input sval_t x);
    if (x[IW-1]) return '0;
    if (x > C_MAX) return '1;
    return x[DATA_W-1:0];
  endfunction

  // S1: centre components; the coefficient set travels with the pixel.
  sval_t      r_s1_yo, r_s1_uo, r_s1_vo;
  logic [1:0] r_s1_sel;
  logic       r_s1_valid, r_s1_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (adv) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_last;
      r_s1_yo    <= sval_t'(in_y) - (cfg_full_range ? sval_t'(0) : C_YOFF);
      r_s1_uo    <= sval_t'(in_u) - C_COFF;
      r_s1_vo    <= sval_t'(in_v) - C_COFF;
      r_s1_sel   <= coef_sel(std_e'(cfg_std), cfg_full_range);
    end
  end

  // S2: products.
  coef_t w_coef;
  sval_t r_s2_py, r_s2_prv, r_s2_pgu, r_s2_pgv, r_s2_pbu;
  logic  r_s2_valid, r_s2_last;

  assign w_coef = COEF_TABLE[r_s1_sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
    end else if (adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_py    <= sval_t'(w_coef.ky)  * r_s1_yo;
      r_s2_prv   <= sval_t'(w_coef.krv) * r_s1_vo;
      r_s2_pgu   <= sval_t'(w_coef.kgu) * r_s1_uo;
      r_s2_pgv   <= sval_t'(w_coef.kgv) * r_s1_vo;
      r_s2_pbu   <= sval_t'(w_coef.kbu) * r_s1_uo;
    end
  end

  // S3: sum, round to nearest, clamp.
  sval_t w_r, w_g, w_b;
  always_comb begin
    w_r = (r_s2_py + r_s2_prv + C_RND) >>> FRAC;
    w_g = (r_s2_py - r_s2_pgu - r_s2_pgv + C_RND) >>> FRAC;
    w_b = (r_s2_py + r_s2_pbu + C_RND) >>> FRAC;
  end

  logic                r_s3_valid, r_s3_last;
  logic [3*DATA_W-1:0] r_s3_pix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
    end else if (adv) begin
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      r_s3_pix   <= {sat(w_r), sat(w_g), sat(w_b)};
    end
  end

  assign s3_valid = r_s3_valid;
  assign s3_last  = r_s3_last;
  assign s3_pix   = r_s3_pix;

`ifdef YUV2RGB_CLAMP_CNT_EN
  logic [1:0] r_s3_clamps;
  always_ff @(posedge clk) begin
    if (adv) begin
      r_s3_clamps <= {1'b0, is_over(w_r)} + {1'b0, is_over(w_g)} + {1'b0, is_over(w_b)};
    end
  end
  assign s3_clamps = r_s3_clamps;
`endif

endmodule
`default_nettype wire

// File: rtl/yuv2rgb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module  : yuv2rgb_stream_packer
// Brief   : YUV->RGB converter packing pixels into wide beats with valid/ready;
//           YUV2RGB_CLAMP_CNT_EN adds a saturating clamp_cnt output.
// Revision: 1.0
// ============================================================================
module yuv2rgb_stream_packer
  import yuv2rgb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PIX_PER_BEAT = 128,
  parameter int FRAC         = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_std,
  input  logic                                cfg_full_range,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_y,
  input  logic [DATA_W-1:0]                   in_u,
  input  logic [DATA_W-1:0]                   in_v,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PIX_PER_BEAT*3*DATA_W-1:0]    out_data,
  output logic [PIX_PER_BEAT-1:0]             out_keep,
  output logic                                out_last
`ifdef YUV2RGB_CLAMP_CNT_EN
  ,
  output logic [31:0]                         clamp_cnt
`endif
);

  localparam int PIX_W  = 3 * DATA_W;
  localparam int BEAT_W = PIX_PER_BEAT * PIX_W;
  localparam int LANE_W = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;

  logic              w_adv, w_s3_valid, w_s3_last, w_close;
  logic [PIX_W-1:0]  w_s3_pix;
  logic [BEAT_W-1:0] r_acc, w_acc_ins;
  logic [LANE_W-1:0] r_lane;
  logic [PIX_PER_BEAT-1:0] w_keep;
  logic              r_out_valid, r_out_last;
  logic [BEAT_W-1:0] r_out_data;
  logic [PIX_PER_BEAT-1:0] r_out_keep;

`ifdef YUV2RGB_CLAMP_CNT_EN
  logic [1:0] w_s3_clamps;
`endif

  yuv2rgb_core #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_core (
    .clk            (clk),
    .rst_n          (rst_n),
    .adv            (w_adv),
    .cfg_std        (cfg_std),
    .cfg_full_range (cfg_full_range),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_y           (in_y),
    .in_u           (in_u),
    .in_v           (in_v),
    .s3_valid       (w_s3_valid),
    .s3_last        (w_s3_last),
    .s3_pix         (w_s3_pix)
`ifdef YUV2RGB_CLAMP_CNT_EN
    ,
    .s3_clamps      (w_s3_clamps)
`endif
  );

  // Only a beat-closing pixel blocked by a full output register stalls the pipe.
  assign w_close  = w_s3_last || (r_lane == LANE_W'(PIX_PER_BEAT - 1));
  assign w_adv    = !(w_s3_valid && w_close && r_out_valid && !out_ready);
  assign in_ready = rst_n && w_adv;

  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[r_lane*PIX_W +: PIX_W] = w_s3_pix;
    for (int k = 0; k < PIX_PER_BEAT; k++) begin
      w_keep[k] = (k <= int'(r_lane));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_lane      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_adv && w_s3_valid) begin
        if (w_close) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_ins;
          r_out_keep  <= w_keep;
          r_out_last  <= w_s3_last;
          r_acc       <= '0;
          r_lane      <= '0;
        end else begin
          r_acc  <= w_acc_ins;
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

`ifdef YUV2RGB_CLAMP_CNT_EN
  logic [31:0] r_clamp_cnt;
  logic [32:0] w_clamp_sum;

  assign w_clamp_sum = {1'b0, r_clamp_cnt} + {31'd0, w_s3_clamps};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clamp_cnt <= '0;
    end else if (w_adv && w_s3_valid) begin
      r_clamp_cnt <= w_clamp_sum[32] ? '1 : w_clamp_sum[31:0];
    end
  end

  assign clamp_cnt = r_clamp_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_yuv2rgb_stream_packer.sv
`default_nettype none
// Bench for yuv2rgb_stream_packer: reference-model scoreboard plus constant vectors.
module tb_yuv2rgb_stream_packer;

  localparam int PPB = 128;
  localparam int PW  = 24;
  localparam int BW  = PPB * PW;

  logic          clk = 1'b0;
  logic          rst_n, cfg_std, cfg_full_range;
  logic          in_valid, in_ready, in_last;
  logic [7:0]    in_y, in_u, in_v;
  logic          out_valid, out_ready, out_last;
  logic [BW-1:0] out_data;
  logic [PPB-1:0] out_keep;
`ifdef YUV2RGB_CLAMP_CNT_EN
  logic [31:0]   clamp_cnt;
`endif

  always #5 clk = ~clk;

  yuv2rgb_stream_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_std        (cfg_std),
    .cfg_full_range (cfg_full_range),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_y           (in_y),
    .in_u           (in_u),
    .in_v           (in_v),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_keep       (out_keep),
    .out_last       (out_last)
`ifdef YUV2RGB_CLAMP_CNT_EN
    ,
    .clamp_cnt      (clamp_cnt)
`endif
  );

  typedef struct {
    logic [BW-1:0]  data;
    logic [PPB-1:0] keep;
    logic           last;
  } beat_t;

  typedef struct {
    int          y, u, v;
    bit          std, full;
    logic [23:0] rgb;
  } vec_t;

  beat_t          exp_q[$];
  int             n_checks, n_fail, n_acc, n_beats;
  logic [BW-1:0]  m_acc;
  int             m_lane;
  longint         m_clamps;
  logic [BW-1:0]  got_data;
  logic [PPB-1:0] got_keep;
  logic           got_last;
  bit             done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic cmp_data(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int bad = 0;
    for (int k = PPB - 1; k >= 0; k--)
      if (act[k*PW +: PW] !== exp[k*PW +: PW]) bad = k;
    chk($sformatf("%s[lane %0d]", name, bad), 128'(act[bad*PW +: PW]), 128'(exp[bad*PW +: PW]));
  endtask

  function automatic logic [23:0] ref_rgb(input int y, u, v, input bit std, full, output int nclamp);
    int k[5];
    int c[3];
    int yo, uo, vo;
    case ({std, full})
      2'b00:   k = '{298, 409, 100, 208, 516};
      2'b01:   k = '{256, 359, 88, 183, 454};
      2'b10:   k = '{298, 459, 55, 136, 541};
      default: k = '{256, 403, 48, 120, 475};
    endcase
    yo = y - (full ? 0 : 16);
    uo = u - 128;
    vo = v - 128;
    c[0] = (k[0]*yo + k[1]*vo + 128) >>> 8;
    c[1] = (k[0]*yo - k[2]*uo - k[3]*vo + 128) >>> 8;
    c[2] = (k[0]*yo + k[4]*uo + 128) >>> 8;
    nclamp = 0;
    for (int i = 0; i < 3; i++) begin
      if (c[i] < 0) begin c[i] = 0; nclamp++; end
      else if (c[i] > 255) begin c[i] = 255; nclamp++; end
    end
    return {c[0][7:0], c[1][7:0], c[2][7:0]};
  endfunction

  // Entered and left at posedge+1; the pixel is accepted at the posedge following an in_ready negedge.
  task automatic send_px(input int y, u, v, input bit last, std, full);
    int n = 0;
    int nc;
    logic [PPB-1:0] km;
    in_y = 8'(y); in_u = 8'(u); in_v = 8'(v);
    in_last = last; cfg_std = std; cfg_full_range = full; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 5000) begin n++; @(negedge clk); end
    if (!in_ready) fail("send_timeout", "in_ready never asserted");
    else begin
      n_acc++;
      m_acc[m_lane*PW +: PW] = ref_rgb(y, u, v, std, full, nc);
      m_clamps += nc;
      if (last || m_lane == PPB - 1) begin
        for (int i = 0; i < PPB; i++) km[i] = (i <= m_lane);
        exp_q.push_back('{m_acc, km, last});
        m_acc = '0;
        m_lane = 0;
      end else m_lane++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) fail("drain_timeout", $sformatf("%0d beats never produced", exp_q.size()));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    m_acc = '0; m_lane = 0; m_clamps = 0; exp_q.delete();
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_keep", 128'(out_keep), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_data_nonzero", 128'(|out_data), 128'(0));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      beat_t e;
      got_data = out_data;
      got_keep = out_keep;
      got_last = out_last;
      n_beats++;
      if (exp_q.size() == 0) fail("unexpected_beat", "beat with no expected entry");
      else begin
        e = exp_q.pop_front();
        cmp_data("beat_data", out_data, e.data);
        chk("beat_keep", 128'(out_keep), 128'(e.keep));
        chk("beat_last", 128'(out_last), 128'(e.last));
      end
    end
  end

  initial begin
    #2000000;
    fail("watchdog", "simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    vec_t tbl[8];
    int   b0, base;
    tbl[0] = '{235, 128, 128, 1'b0, 1'b0, 24'hFFFFFF};
    tbl[1] = '{16,  128, 255, 1'b0, 1'b0, 24'hCB0000};
    tbl[2] = '{128, 128, 128, 1'b1, 1'b1, 24'h808080};
    tbl[3] = '{16,  128, 128, 1'b0, 1'b0, 24'h000000};
    tbl[4] = '{0,   0,   0,   1'b0, 1'b1, 24'h008800};
    tbl[5] = '{100, 200, 50,  1'b1, 1'b0, 24'h007CFA};
    tbl[6] = '{255, 255, 255, 1'b1, 1'b1, 24'hFFACFF};
    tbl[7] = '{128, 100, 160, 1'b0, 1'b1, 24'hAD734E};

    n_checks = 0; n_fail = 0; n_acc = 0; n_beats = 0; done = 1'b0;
    m_acc = '0; m_lane = 0; m_clamps = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_y = '0; in_u = '0; in_v = '0;
    cfg_std = 1'b0; cfg_full_range = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset(3);

    // Full white beat
    b0 = n_beats;
    for (int i = 0; i < PPB; i++) send_px(235, 128, 128, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("t1_beats", 128'(n_beats - b0), 128'(1));
    chk("t1_keep", 128'(got_keep), {128{1'b1}});
    chk("t1_last", 128'(got_last), 128'(0));
    chk("t1_lane127", 128'(got_data[127*PW +: PW]), 128'(24'hFFFFFF));

    // Single-pixel beats against constant results
    for (int i = 0; i < 8; i++) begin
      send_px(tbl[i].y, tbl[i].u, tbl[i].v, 1'b1, tbl[i].std, tbl[i].full);
      wait_drain();
      chk($sformatf("vec%0d_rgb", i), 128'(got_data[PW-1:0]), 128'(tbl[i].rgb));
      chk($sformatf("vec%0d_keep", i), 128'(got_keep), 128'(1));
`ifdef YUV2RGB_CLAMP_CNT_EN
      chk($sformatf("vec%0d_clamp_cnt", i), 128'(clamp_cnt), 128'(m_clamps));
`endif
    end

    // Short line closed by in_last
    for (int i = 0; i < 5; i++) send_px(i * 40, 100, 150, i == 4, 1'b0, 1'b0);
    wait_drain();
    chk("t3_keep", 128'(got_keep), 128'h1F);
    chk("t3_last", 128'(got_last), 128'(1));
    chk("t3_upper_lanes_nonzero", 128'(|got_data[BW-1:5*PW]), 128'(0));

    // Configuration switch between pixels of one beat; starts at lane 0
    for (int i = 0; i < 8; i++)
      send_px(i < 4 ? 128 : 235, 128, 128, i == 7, i < 4, i < 4);
    wait_drain();
    chk("t6_lane3_709full", 128'(got_data[3*PW +: PW]), 128'(24'h808080));
    chk("t6_lane4_601lim", 128'(got_data[4*PW +: PW]), 128'(24'hFFFFFF));
    chk("t6_keep", 128'(got_keep), 128'hFF);

    // Full backpressure
    b0 = n_beats;
    base = n_acc;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 300; i++) send_px(i & 255, (i * 3) & 255, 255 - (i & 255), 1'b0, 1'b0, 1'b0);
      begin
        repeat (400) @(negedge clk);
        chk("t4_accepted_at_stall", 128'(n_acc - base), 128'(258));
        chk("t4_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    send_px(7, 8, 9, 1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("t4_beats", 128'(n_beats - b0), 128'(3));

    // Reset in the middle of a partial beat
    for (int i = 0; i < 60; i++) send_px(200, i, 255 - i, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    b0 = n_beats;
    for (int i = 0; i < PPB; i++) send_px(i, 128, 128 + (i & 63), 1'b0, 1'b0, 1'b1);
    wait_drain();
    chk("t5_beats", 128'(n_beats - b0), 128'(1));
    chk("t5_keep", 128'(got_keep), {128{1'b1}});

    // Random stream with gaps, random configuration and random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          send_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        send_px(1, 2, 3, 1'b1, 1'b0, 1'b0);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("rand_queue_empty", 128'(exp_q.size()), 128'(0));
`ifdef YUV2RGB_CLAMP_CNT_EN
    chk("final_clamp_cnt", 128'(clamp_cnt), 128'(m_clamps));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
